// File: rtl/inst_sram_resp.sv
// ============================================================================
// Module   : inst_sram_resp
// Brief    : Single-port instruction SRAM responder with fixed 1-cycle read
//            latency, byte-lane writes, out-of-range trapping and access counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_sram_resp #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        addr_err,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ERR  = 1'b1
    } state_t;

    state_t              r_state;
    logic [31:0]         r_mem [c_DEPTH];
    logic [31:0]         r_rdata;
    logic [31:0]         r_err_addr;
    logic [31:0]         r_rd_cnt;
    logic [31:0]         r_wr_cnt;

    logic [31:0]         w_offset;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_index;
    logic                w_is_write;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_oor;

    // Modular subtraction folds addresses below BASE into the huge-offset range.
    assign w_offset   = inst_sram_addr - BASE;
    assign w_in_range = (w_offset[31:ADDR_W+2] == '0);
    assign w_index    = w_offset[ADDR_W+1:2];
    assign w_is_write = (inst_sram_wen != 4'b0000);
    assign w_rd_ok    = inst_sram_en && w_in_range && !w_is_write;
    assign w_wr_ok    = inst_sram_en && w_in_range &&  w_is_write;
    assign w_oor      = inst_sram_en && !w_in_range;

    // Storage is never reset; reset only blocks a same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    r_mem[w_index][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first: the sampled word is the pre-write value on a write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (inst_sram_en) begin
            r_rdata <= w_in_range ? r_mem[w_index] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= 32'h0;
            r_wr_cnt <= 32'h0;
        end else begin
            if (w_rd_ok) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr_ok) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_err_addr <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_oor) begin
                        r_state    <= ERR;
                        r_err_addr <= inst_sram_addr;
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inst_sram_rdata = r_rdata;
    assign addr_err        = (r_state == ERR);
    assign err_addr        = r_err_addr;
    assign rd_cnt          = r_rd_cnt;
    assign wr_cnt          = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_sram_resp.sv
// ============================================================================
// Module   : tb_inst_sram_resp
// Brief    : Directed self-checking bench for inst_sram_resp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_sram_resp;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_err;
    logic [31:0] err_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int n_vec;
    int n_err;

    inst_sram_resp #(
        .ADDR_W (12),
        .BASE   (32'h1c000000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (en),
        .inst_sram_wen   (wen),
        .inst_sram_addr  (addr),
        .inst_sram_wdata (wdata),
        .inst_sram_rdata (rdata),
        .addr_err        (addr_err),
        .err_addr        (err_addr),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at negedge; outputs are sampled at the next negedge.
    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b0;
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL reset_rd_cnt got %h exp 0", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL reset_wr_cnt got %h exp 0", wr_cnt); end
    endtask

    task automatic test_write_read();
        cyc(1'b1, 4'hf, 32'h1c000000, 32'hdeadbeef);
        cyc(1'b1, 4'h0, 32'h1c000000, 32'h0);
        n_vec++; if (rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL wr_rd_data got %h exp deadbeef", rdata); end
        n_vec++; if (wr_cnt !== 32'd1) begin n_err++; $display("FAIL wr_rd_wr_cnt got %0d exp 1", wr_cnt); end
        n_vec++; if (rd_cnt !== 32'd1) begin n_err++; $display("FAIL wr_rd_rd_cnt got %0d exp 1", rd_cnt); end
    endtask

    task automatic test_byte_lanes();
        cyc(1'b1, 4'hf, 32'h1c000010, 32'h11223344);
        cyc(1'b1, 4'b0101, 32'h1c000010, 32'haabbccdd);
        n_vec++; if (rdata !== 32'h11223344) begin n_err++; $display("FAIL read_first got %h exp 11223344", rdata); end
        cyc(1'b1, 4'h0, 32'h1c000010, 32'h0);
        n_vec++; if (rdata !== 32'h11bb33dd) begin n_err++; $display("FAIL byte_lanes got %h exp 11bb33dd", rdata); end
        n_vec++; if (wr_cnt !== 32'd3) begin n_err++; $display("FAIL lanes_wr_cnt got %0d exp 3", wr_cnt); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 4'hf, 32'h1c000004, 32'h55667788);
        cyc(1'b1, 4'h0, 32'h1c000000, 32'h0);
        n_vec++; if (rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL b2b_rd0 got %h exp deadbeef", rdata); end
        cyc(1'b1, 4'h0, 32'h1c000004, 32'h0);
        n_vec++; if (rdata !== 32'h55667788) begin n_err++; $display("FAIL b2b_rd1 got %h exp 55667788", rdata); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 32'h1c000000, 32'h0);
            n_vec++; if (rdata !== 32'h55667788) begin n_err++; $display("FAIL b2b_hold%0d got %h exp 55667788", i, rdata); end
        end
        cyc(1'b1, 4'h0, 32'h1c000003, 32'h0);
        n_vec++; if (rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL unaligned got %h exp deadbeef", rdata); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL unaligned_err got %b exp 0", addr_err); end
        cyc(1'b1, 4'hf, 32'h1c003ffc, 32'h0badf00d);
        cyc(1'b1, 4'h0, 32'h1c003ffc, 32'h0);
        n_vec++; if (rdata !== 32'h0badf00d) begin n_err++; $display("FAIL top_word got %h exp 0badf00d", rdata); end
        n_vec++; if (rd_cnt !== 32'd6) begin n_err++; $display("FAIL b2b_rd_cnt got %0d exp 6", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'd5) begin n_err++; $display("FAIL b2b_wr_cnt got %0d exp 5", wr_cnt); end
    endtask

    task automatic test_out_of_range();
        cyc(1'b1, 4'h0, 32'h1c004000, 32'h0);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL oor_rdata0 got %h exp 0", rdata); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_flag got %b exp 1", addr_err); end
        n_vec++; if (err_addr !== 32'h1c004000) begin n_err++; $display("FAIL oor_addr got %h exp 1c004000", err_addr); end
        cyc(1'b1, 4'h0, 32'h00000000, 32'h0);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL oor_rdata1 got %h exp 0", rdata); end
        n_vec++; if (err_addr !== 32'h1c004000) begin n_err++; $display("FAIL oor_addr_sticky got %h exp 1c004000", err_addr); end
        cyc(1'b1, 4'hf, 32'h1c004000, 32'h77777777);
        n_vec++; if (rd_cnt !== 32'd6) begin n_err++; $display("FAIL oor_rd_cnt got %0d exp 6", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'd5) begin n_err++; $display("FAIL oor_wr_cnt got %0d exp 5", wr_cnt); end
        cyc(1'b1, 4'h0, 32'h1c000000, 32'h0);
        n_vec++; if (rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL oor_no_write got %h exp deadbeef", rdata); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_flag_hold got %b exp 1", addr_err); end
    endtask

    task automatic test_reset_midstream();
        cyc(1'b1, 4'hf, 32'h1c000020, 32'h12345678);
        reset = 1'b1;
        cyc(1'b1, 4'hf, 32'h1c000020, 32'hcafef00d);
        reset = 1'b0;
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mrst_rdata got %h exp 0", rdata); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL mrst_flag got %b exp 0", addr_err); end
        n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL mrst_err_addr got %h exp 0", err_addr); end
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL mrst_rd_cnt got %0d exp 0", rd_cnt); end
        n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL mrst_wr_cnt got %0d exp 0", wr_cnt); end
        cyc(1'b1, 4'h0, 32'h1c000020, 32'h0);
        n_vec++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL mrst_no_write got %h exp 12345678", rdata); end
        cyc(1'b1, 4'h0, 32'h1c000000, 32'h0);
        n_vec++; if (rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL mrst_mem_kept got %h exp deadbeef", rdata); end
        n_vec++; if (rd_cnt !== 32'd2) begin n_err++; $display("FAIL mrst_rd_cnt2 got %0d exp 2", rd_cnt); end
    endtask

    task automatic test_rd_wrap();
        force dut.r_rd_cnt = 32'hffffffff;
        #1;
        release dut.r_rd_cnt;
        n_vec++; if (rd_cnt !== 32'hffffffff) begin n_err++; $display("FAIL wrap_preload got %h exp ffffffff", rd_cnt); end
        cyc(1'b1, 4'h0, 32'h1c000004, 32'h0);
        n_vec++; if (rd_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_rd_cnt got %h exp 0", rd_cnt); end
        n_vec++; if (rdata !== 32'h55667788) begin n_err++; $display("FAIL wrap_rdata got %h exp 55667788", rdata); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_out_of_range();
        test_reset_midstream();
        test_rd_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width; depth = 2^ADDR_W words of 32 bits.
REQ-002 SHALL have parameter BASE, default 32'h1c000000, byte address of word 0.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port inst_sram_en, input, 1, access request this cycle.
REQ-006 SHALL have port inst_sram_wen, input, 4, byte write enables; 0 means read.
REQ-007 SHALL have port inst_sram_addr, input, 32, byte address.
REQ-008 SHALL have port inst_sram_wdata, input, 32, write data.
REQ-009 SHALL have port inst_sram_rdata, output, 32, registered read data.
REQ-010 SHALL have port addr_err, output, 1, sticky out-of-range access flag.
REQ-011 SHALL have port err_addr, output, 32, byte address of the first out-of-range access.
REQ-012 SHALL have port rd_cnt, output, 32, count of accepted in-range reads.
REQ-013 SHALL have port wr_cnt, output, 32, count of accepted in-range writes.

Function
REQ-014 SHALL treat an access as in range iff inst_sram_addr - BASE (32-bit modular) < 4*2^ADDR_W; word index = bits [ADDR_W+1:2] of that difference.
REQ-015 SHALL ignore inst_sram_addr[1:0] for indexing; unaligned addresses do not set addr_err.
REQ-016 SHALL, on en=1, wen=0, in range, present mem[index] on inst_sram_rdata exactly one cycle later (fixed latency 1, no stall, no backpressure).
REQ-017 SHALL, on en=1, wen!=0, in range, write each byte lane i with wdata[8i+7:8i] where wen[i]=1; other lanes unchanged.
REQ-018 SHALL be read-first: on a write cycle, rdata next cycle = pre-write word at that index.
REQ-019 SHALL, on a read in the cycle after a write to the same index, return the newly written word.
REQ-020 SHALL hold inst_sram_rdata unchanged in any cycle following en=0.
REQ-021 SHALL, on en=1 out of range, drive inst_sram_rdata=0 next cycle, suppress any write, and leave memory unchanged.
REQ-022 SHALL, on the first out-of-range access after reset, set addr_err=1 and capture err_addr; later out-of-range accesses SHALL NOT update err_addr.
REQ-023 SHALL increment rd_cnt by 1 per in-range read and wr_cnt by 1 per in-range write, the cycle after the access; both wrap 32'hffffffff -> 0.
REQ-024 SHALL NOT count out-of-range accesses or en=0 cycles.
REQ-025 SHALL have two states, IDLE (no error latched) and ERR (addr_err=1); IDLE->ERR on out-of-range access; ERR exits only on reset.

Reset
REQ-026 SHALL, on reset, drive inst_sram_rdata=0, addr_err=0, err_addr=0, rd_cnt=0, wr_cnt=0, state IDLE.
REQ-027 SHALL NOT clear or modify memory contents on reset.
REQ-028 SHALL give reset priority over a same-cycle access: no write, no count, rdata=0 next cycle.
REQ-029 SHALL, after reset deasserts, accept an access in the first cycle with normal 1-cycle latency.

Verification
REQ-030 Write 32'hdeadbeef wen=4'hf to 0x1c000000, then read 0x1c000000 -> rdata=32'hdeadbeef one cycle after read; wr_cnt=1, rd_cnt=1.
REQ-031 Word 0x1c000010 = 32'h11223344; write wdata=32'haabbccdd wen=4'b0101 -> rdata that cycle+1 = 32'h11223344; next read = 32'h11bb33dd.
REQ-032 Back-to-back reads 0x1c000000, 0x1c000004, then en=0 for 3 cycles -> rdata tracks each word at +1 cycle, then holds last word 3 cycles.
REQ-033 Read 0x1c004000 (ADDR_W=12), then read 0x00000000 -> rdata=0 both; addr_err=1; err_addr=32'h1c004000; rd_cnt unchanged.
REQ-034 Assert reset mid-stream with en=1 wen=4'hf to 0x1c000020 -> word 0x1c000020 unchanged; counters, addr_err, rdata all 0; previously written 0x1c000000 still reads back its value.
REQ-035 Preload rd_cnt path with 2^32-1 reads (or force) then one more read -> rd_cnt=0.
